max_vector_stream_ctrl: RTL and testbench

- Sequencer that computes the signed maximum of a long vector, streamed as LANES-wide beats, by driving the existing 3-stage 8-lane max pipeline.
- Accepts beats from an upstream valid/ready source, issues them to the pipeline, and counts returning results.
- Reduces the returned results into a running maximum and the index of the beat that holds it.
- Sits between the vector producer and the max pipeline, and reports one result per job with a done pulse.

---
 rtl/max_vec_pkg.sv | 13 +
 rtl/max_vec_accum.sv | 37 +++
 rtl/max_vector_stream_ctrl.sv | 130 +++++++++++++
 tb/tb_max_vector_stream_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/max_vec_pkg.sv
// Shared constants, data types and controller state encoding for the
// streamed vector-max sequencer.
package max_vec_pkg;
    localparam int DATA_W   = 8;
    localparam int LANES    = 8;
    localparam int PIPE_LAT = 3;
    localparam int CNT_W    = 8;

    typedef logic signed [DATA_W-1:0] elem_t;
    typedef logic [LANES*DATA_W-1:0]  beat_t;

    typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/max_vec_accum.sv
// Running signed maximum and the index of the beat that produced it.
// The next-state value is exported so the final return can be reported without an extra cycle.
module max_vec_accum #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     upd,
    input  logic signed [DATA_W-1:0] value,
    input  logic [CNT_W-1:0]         idx,
    output logic signed [DATA_W-1:0] acc_nxt,
    output logic [CNT_W-1:0]         idx_nxt
);
    logic signed [DATA_W-1:0] acc;
    logic [CNT_W-1:0]         acc_idx;
    logic                     acc_valid;
    logic                     take;

    // Strict compare so a tie leaves the earlier index in place.
    assign take    = upd && (!acc_valid || (value > acc));
    assign acc_nxt = take ? value : acc;
    assign idx_nxt = take ? idx : acc_idx;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc       <= '0;
            acc_idx   <= '0;
            acc_valid <= 1'b0;
        end else if (take) begin
            acc       <= value;
            acc_idx   <= idx;
            acc_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/max_vector_stream_ctrl.sv
// Feeds a job of N beats into the max pipeline, counts the returning results and
// reduces them to the job maximum and its beat index, with a done pulse per job.
module max_vector_stream_ctrl #(
    parameter int DATA_W   = max_vec_pkg::DATA_W,
    parameter int LANES    = max_vec_pkg::LANES,
    parameter int PIPE_LAT = max_vec_pkg::PIPE_LAT,
    parameter int CNT_W    = max_vec_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_beats,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      pipe_valid_in,
    output logic [LANES*DATA_W-1:0]   pipe_data,
    input  logic signed [DATA_W-1:0]  pipe_result,
    input  logic                      pipe_valid_out,
    output logic signed [DATA_W-1:0]  max_out,
    output logic [CNT_W-1:0]          max_idx,
    output logic                      done,
    output logic                      err,
    output max_vec_pkg::state_t       dbg_state
);
    import max_vec_pkg::*;

    localparam int FL_W = $clog2(PIPE_LAT + 2);

    state_t                   state;
    logic [FL_W-1:0]          flush_cnt;
    logic [CNT_W-1:0]         n_beats;
    logic [CNT_W-1:0]         issued;
    logic [CNT_W-1:0]         returned;
    logic [CNT_W-1:0]         issued_inc;
    logic [CNT_W-1:0]         returned_inc;
    logic                     issue_hs;
    logic                     ret_hs;
    logic                     acc_clr;
    logic signed [DATA_W-1:0] acc_nxt;
    logic [CNT_W-1:0]         idx_nxt;

    // A beat transfers on any cycle where in_valid and in_ready are both high; the
    // source may hold in_valid low for any number of cycles, and in_ready never
    // depends combinationally on in_valid.
    assign issue_hs      = in_valid & in_ready;
    assign pipe_valid_in = issue_hs;
    assign pipe_data     = in_data;

    assign ret_hs       = pipe_valid_out && ((state == ISSUE) || (state == DRAIN))
                          && (returned != n_beats);
    assign acc_clr      = (state == IDLE) && start && (num_beats != '0);
    assign issued_inc   = issued + 1'b1;
    assign returned_inc = returned + 1'b1;
    assign dbg_state    = state;

    max_vec_accum #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_accum (
        .clk     (clk),
        .rst     (rst),
        .clr     (acc_clr),
        .upd     (ret_hs),
        .value   (pipe_result),
        .idx     (returned),
        .acc_nxt (acc_nxt),
        .idx_nxt (idx_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FLUSH;
            flush_cnt <= FL_W'(PIPE_LAT);
            n_beats   <= '0;
            issued    <= '0;
            returned  <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            max_out   <= '0;
            max_idx   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (ret_hs) returned <= returned_inc;
            case (state)
                // Results still in flight from before reset drain out here unseen.
                FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt <= FL_W'(1)) state <= IDLE;
                end
                IDLE: begin
                    if (start) begin
                        if (num_beats == '0) begin
                            err <= 1'b1;
                        end else begin
                            n_beats  <= num_beats;
                            issued   <= '0;
                            returned <= '0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_hs) begin
                        issued <= issued_inc;
                        if (issued_inc == n_beats) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                // The final return lands on the same edge that publishes the result.
                DRAIN: begin
                    if (ret_hs && (returned_inc == n_beats)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        max_out <= acc_nxt;
                        max_idx <= idx_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= FLUSH;
            endcase
        end
    end
endmodule

// File: tb/tb_max_vector_stream_ctrl.sv
// Directed job table plus hand-written reset, zero-length and start-while-busy
// sequences, run against the controller wrapped around a 3-stage lane-max pipeline.
module tb_max_vector_stream_ctrl;
    import max_vec_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [CNT_W-1:0]         num_beats;
    logic                     busy;
    logic                     in_valid;
    logic                     in_ready;
    beat_t                    in_data;
    logic                     pipe_valid_in;
    beat_t                    pipe_data;
    elem_t                    pipe_result;
    logic                     pipe_valid_out;
    elem_t                    max_out;
    logic [CNT_W-1:0]         max_idx;
    logic                     done;
    logic                     err;
    state_t                   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    max_vector_stream_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_beats      (num_beats),
        .busy           (busy),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .pipe_valid_in  (pipe_valid_in),
        .pipe_data      (pipe_data),
        .pipe_result    (pipe_result),
        .pipe_valid_out (pipe_valid_out),
        .max_out        (max_out),
        .max_idx        (max_idx),
        .done           (done),
        .err            (err),
        .dbg_state      (dbg_state)
    );

    // Three-stage lane-max pipeline; valid bits are deliberately not reset.
    logic  s1_v = 1'b0, s2_v = 1'b0, s3_v = 1'b0;
    beat_t s1_d = '0;
    elem_t s2_m = '0, s3_m = '0;

    function automatic elem_t lane_max(input beat_t b);
        elem_t m, e;
        m = b[DATA_W-1:0];
        for (int i = 1; i < LANES; i++) begin
            e = b[i*DATA_W +: DATA_W];
            if (e > m) m = e;
        end
        return m;
    endfunction

    always @(posedge clk) begin
        s1_v <= pipe_valid_in;
        s1_d <= pipe_data;
        s2_v <= s1_v;
        s2_m <= lane_max(s1_d);
        s3_v <= s2_v;
        s3_m <= s2_m;
    end
    assign pipe_valid_out = s3_v;
    assign pipe_result    = s3_m;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic beat_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int    v[8];
        beat_t b;
        v = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int i = 0; i < LANES; i++) b[i*DATA_W +: DATA_W] = elem_t'(v[i]);
        return b;
    endfunction

    typedef struct {
        int         n;
        beat_t      beats[5];
        logic [7:0] pat;
        int         plen;
        bit         poke;
        int         exp_max;
        int         exp_idx;
        int         exp_rdy;
    } job_t;

    job_t jobs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int exp_cycles);
        int k;
        k = 0;
        while (dbg_state != IDLE && k < 20) begin
            tick();
            k++;
        end
        chk(nm, k, exp_cycles);
    endtask

    task automatic run_job(input int j);
        int    b, step, rdy, lat, d0, e0;
        bit    seen;
        logic  hs;
        logic [15:0] got;
        d0 = done_cnt;
        e0 = err_cnt;
        exp_q.push_back({8'(jobs[j].exp_max), 8'(jobs[j].exp_idx)});
        start     = 1'b1;
        num_beats = CNT_W'(jobs[j].n);
        tick();
        start = 1'b0;
        b = 0; step = 0; rdy = 0;
        while (b < jobs[j].n && step < 100) begin
            in_valid  = (step < jobs[j].plen) ? jobs[j].pat[step] : 1'b1;
            in_data   = jobs[j].beats[b];
            start     = jobs[j].poke && (step == 1);
            num_beats = start ? '0 : CNT_W'(jobs[j].n);
            @(negedge clk);
            hs = in_valid & in_ready;
            if (in_ready) rdy++;
            tick();
            if (hs) b++;
            step++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        lat = 0; seen = 0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy++;
            if (done) begin
                seen = 1;
                got  = exp_q.pop_front();
                chk($sformatf("job%0d_max", j), int'(max_out), int'($signed(got[15:8])));
                chk($sformatf("job%0d_idx", j), int'(max_idx), int'(got[7:0]));
                chk($sformatf("job%0d_busy_at_done", j), int'(busy), 0);
                chk($sformatf("job%0d_returned", j), int'(dut.returned), jobs[j].n);
            end
        end
        chk($sformatf("job%0d_done_seen", j), int'(seen), 1);
        chk($sformatf("job%0d_latency", j), lat, 4);
        chk($sformatf("job%0d_ready_cycles", j), rdy, jobs[j].exp_rdy);
        if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        chk($sformatf("job%0d_done_pulse_len", j), int'(done), 0);
        tick(); tick(); tick();
        chk($sformatf("job%0d_done_count", j), done_cnt - d0, 1);
        chk($sformatf("job%0d_no_err", j), err_cnt - e0, 0);
    endtask

    initial begin
        jobs[0] = '{n: 1, beats: '{mk(3, -7, 12, 0, 5, -1, 2, 9), '0, '0, '0, '0},
                    pat: 8'h00, plen: 0, poke: 0, exp_max: 12, exp_idx: 0, exp_rdy: 1};
        jobs[1] = '{n: 4, beats: '{mk(1, 5, -3, 0, 2, 4, -8, 3), mk(-2, -5, -9, -128, -3, -2, -7, -4),
                                   mk(0, 40, 1, 2, -40, 39, 3, 4), mk(40, 0, 0, 0, 0, 0, 0, -1), '0},
                    pat: 8'h00, plen: 0, poke: 0, exp_max: 40, exp_idx: 2, exp_rdy: 4};
        jobs[2] = '{n: 3, beats: '{mk(-128, -128, -128, -128, -128, -128, -128, -128),
                                   mk(-128, -128, -128, -100, -128, -128, -128, -128),
                                   mk(-128, -128, -128, -128, -128, -128, -128, -128), '0, '0},
                    pat: 8'b0010_1001, plen: 6, poke: 0, exp_max: -100, exp_idx: 1, exp_rdy: 6};
        jobs[3] = '{n: 2, beats: '{mk(100, -1, 0, 0, 0, 0, 0, 99), mk(0, 0, 0, 0, 0, 0, 0, 127), '0, '0, '0},
                    pat: 8'b0000_0101, plen: 3, poke: 1, exp_max: 127, exp_idx: 1, exp_rdy: 3};
        jobs[4] = '{n: 3, beats: '{mk(-1, -1, -1, -1, -1, -1, -1, -1), mk(-1, -1, -1, -1, -1, -1, -1, -1),
                                   mk(-1, -1, -1, -1, -1, -1, -1, -1), '0, '0},
                    pat: 8'h00, plen: 0, poke: 0, exp_max: -1, exp_idx: 0, exp_rdy: 3};
        jobs[5] = '{n: 1, beats: '{mk(7, 1, 0, -3, 2, 6, -8, 0), '0, '0, '0, '0},
                    pat: 8'h00, plen: 0, poke: 0, exp_max: 7, exp_idx: 0, exp_rdy: 1};

        rst = 1'b1; start = 1'b0; num_beats = '0; in_valid = 1'b0; in_data = '0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_max_out", int'(max_out), 0);
        chk("rst_max_idx", int'(max_idx), 0);
        chk("rst_state", int'(dbg_state), int'(FLUSH));
        tick();
        rst = 1'b0;
        wait_idle("flush_cycles", PIPE_LAT);

        run_job(0);

        start = 1'b1; num_beats = '0;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("zero_err", int'(err), 1);
        chk("zero_busy", int'(busy), 0);
        chk("zero_done", int'(done), 0);
        chk("zero_state", int'(dbg_state), int'(IDLE));
        @(negedge clk);
        chk("zero_err_pulse_len", int'(err), 0);
        chk("zero_busy_after", int'(busy), 0);
        tick();

        run_job(1);
        run_job(2);
        run_job(3);
        run_job(4);

        begin
            int d0;
            d0 = done_cnt;
            start = 1'b1; num_beats = CNT_W'(5);
            tick();
            start = 1'b0;
            in_valid = 1'b1;
            in_data  = mk(50, 0, 0, 0, 0, 0, 0, 0);
            tick();
            in_data  = mk(60, 0, 0, 0, 0, 0, 0, 0);
            tick();
            in_valid = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            @(negedge clk);
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_in_ready", int'(in_ready), 0);
            chk("midrst_state", int'(dbg_state), int'(FLUSH));
            tick();
            wait_idle("midrst_flush_cycles", PIPE_LAT - 1);
            tick(); tick(); tick();
            chk("midrst_no_done", done_cnt - d0, 0);
            chk("midrst_busy_idle", int'(busy), 0);
        end

        run_job(5);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
